// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM between display fetch and game-logic reads. The grant is combinational.
// Read data returns one cycle after the grant. Display has priority, and a starved CPU request is forced through.
module sprite_rom_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 3,
  parameter int STARVE_MAX = 8
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              disp_miss,
  output logic [15:0]       miss_count
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t      owner_q;
  owner_t      owner_d;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic [15:0] miss_cnt_q;
  logic [15:0] miss_cnt_d;
  logic        force_cpu;

  assign force_cpu = cpu_req && (starve_q == STARVE_LIM);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= OWN_NONE;
      starve_q   <= 4'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // The grant decides both the ROM address and the owner of the next cycle's read data.
  always_comb begin
    owner_d  = OWN_NONE;
    disp_gnt = 1'b0;
    cpu_gnt  = 1'b0;
    rom_addr = '0;
    if (reset_n) begin
      if (force_cpu || (cpu_req && !disp_req)) begin
        cpu_gnt  = 1'b1;
        rom_addr = cpu_addr;
        owner_d  = OWN_CPU;
      end else if (disp_req) begin
        disp_gnt = 1'b1;
        rom_addr = disp_addr;
        owner_d  = OWN_DISP;
      end
    end
  end

  // The counter is bounded by STARVE_MAX: once it reaches that value, the CPU is granted.
  always_comb begin
    starve_d = 4'd0;
    if (cpu_req && !cpu_gnt) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign disp_miss = reset_n && disp_req && !disp_gnt;

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (disp_miss && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  assign miss_count = miss_cnt_q;

  assign disp_valid = (owner_q == OWN_DISP);
  assign cpu_valid  = (owner_q == OWN_CPU);
  assign disp_data  = disp_valid ? rom_q : '0;
  assign cpu_data   = cpu_valid  ? rom_q : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomised and directed checks of sprite_rom_arbiter against a cycle-level reference model.
module tb_sprite_rom_arbiter;
  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 3;
  localparam int STARVE_MAX = 8;

  logic              vga_clk;
  logic              reset_n;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              disp_miss;
  logic [15:0]       miss_count;

  sprite_rom_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_gnt  (disp_gnt),
    .disp_valid(disp_valid),
    .disp_data (disp_data),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_gnt   (cpu_gnt),
    .cpu_valid (cpu_valid),
    .cpu_data  (cpu_data),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .disp_miss (disp_miss),
    .miss_count(miss_count)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic [DATA_W-1:0] rom_mem [0:(1<<ADDR_W)-1];
  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

  int checks = 0;
  int errors = 0;

  // Reference model state: consecutive CPU denials, miss count, and who owns the read in flight.
  int m_denied = 0;
  int m_miss   = 0;
  int m_own    = 0;   // 0 none, 1 display, 2 cpu
  int m_addr   = 0;
  int last_cgnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Call with inputs already driven just after a falling edge; returns at the next falling edge.
  task automatic step();
    int e_cgnt, e_dgnt, e_addr, e_miss, e_dv, e_cv, e_dd, e_cd;
    #1;
    if (!reset_n) begin
      m_denied = 0;
      m_miss   = 0;
      m_own    = 0;
    end
    e_cgnt = (reset_n && cpu_req && (m_denied == STARVE_MAX || !disp_req)) ? 1 : 0;
    e_dgnt = (reset_n && disp_req && e_cgnt == 0) ? 1 : 0;
    e_addr = e_dgnt != 0 ? int'(disp_addr) : (e_cgnt != 0 ? int'(cpu_addr) : 0);
    e_miss = (reset_n && disp_req && e_dgnt == 0) ? 1 : 0;
    e_dv   = (m_own == 1) ? 1 : 0;
    e_cv   = (m_own == 2) ? 1 : 0;
    e_dd   = (m_own == 1) ? int'(rom_mem[m_addr]) : 0;
    e_cd   = (m_own == 2) ? int'(rom_mem[m_addr]) : 0;
    chk("disp_gnt",   int'(disp_gnt),   e_dgnt);
    chk("cpu_gnt",    int'(cpu_gnt),    e_cgnt);
    chk("rom_addr",   int'(rom_addr),   e_addr);
    chk("disp_miss",  int'(disp_miss),  e_miss);
    chk("disp_valid", int'(disp_valid), e_dv);
    chk("cpu_valid",  int'(cpu_valid),  e_cv);
    chk("disp_data",  int'(disp_data),  e_dd);
    chk("cpu_data",   int'(cpu_data),   e_cd);
    chk("miss_count", int'(miss_count), m_miss);
    last_cgnt = int'(cpu_gnt);
    @(posedge vga_clk);
    if (reset_n) begin
      m_denied = (cpu_req && e_cgnt == 0) ? m_denied + 1 : 0;
      if (e_miss != 0 && m_miss < 65535) m_miss++;
      m_own  = e_dgnt != 0 ? 1 : (e_cgnt != 0 ? 2 : 0);
      m_addr = e_addr;
    end
    @(negedge vga_clk);
  endtask

  task automatic drive(input logic dr, input int da, input logic cr, input int ca);
    disp_req  = dr;
    disp_addr = ADDR_W'(da);
    cpu_req   = cr;
    cpu_addr  = ADDR_W'(ca);
  endtask

  initial begin
    int first_force;
    int second_force;
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);
    reset_n = 1'b0;
    drive(1'b1, 5, 1'b1, 7);
    @(negedge vga_clk);
    for (int i = 0; i < 3; i++) step();

    reset_n = 1'b1;
    for (int a = 0; a < 5; a++) begin
      drive(1'b1, a, 1'b0, 0);
      step();
    end

    drive(1'b0, 0, 1'b1, 13'h0100);
    step();
    drive(1'b0, 0, 1'b0, 0);
    step();

    first_force  = 0;
    second_force = 0;
    drive(1'b1, int'($urandom_range(0, 8191)), 1'b1, int'($urandom_range(0, 8191)));
    for (int k = 1; k <= 20; k++) begin
      step();
      if (last_cgnt != 0 && first_force == 0) first_force = k;
      else if (last_cgnt != 0 && second_force == 0) second_force = k;
    end
    chk("starve_first_force", first_force, 9);
    chk("starve_second_force", second_force, 18);
    drive(1'b0, 0, 1'b0, 0);
    step();

    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) drive(1'b1, int'($urandom_range(0, 8191)), 1'b0, 0);
      else            drive(1'b0, 0, 1'b1, int'($urandom_range(0, 8191)));
      step();
    end

    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 8191)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 8191)));
      step();
    end

    // Preload the miss counter just below saturation, then keep the display starved.
    drive(1'b0, 0, 1'b0, 0);
    step();
    force dut.miss_cnt_q = 16'hFFF0;
    #1;
    release dut.miss_cnt_q;
    m_miss = 16'hFFF0;
    drive(1'b1, 3, 1'b1, 4);
    for (int k = 0; k < 300; k++) step();
    chk("miss_saturated", int'(miss_count), 16'hFFFF);

    drive(1'b0, 0, 1'b0, 0);
    step();
    drive(1'b0, 0, 1'b1, 13'h0123);
    #1;
    chk("midflight_cpu_gnt", int'(cpu_gnt), 1);
    #1;
    reset_n = 1'b0;
    m_denied = 0;
    m_miss   = 0;
    m_own    = 0;
    @(negedge vga_clk);
    drive(1'b0, 0, 1'b0, 0);
    for (int k = 0; k < 2; k++) step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("post_reset_miss_count", int'(miss_count), 0);

    drive(1'b1, 9, 1'b0, 0);
    step();
    drive(1'b0, 0, 1'b0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, meaning sprite ROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 3, meaning palette index width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 8, meaning consecutive denied CPU cycles before a forced CPU grant; legal range 1-15.
REQ-004 vga_clk  in  1  sole clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 disp_req  in  1  display pixel-fetch request.
REQ-007 disp_addr  in  ADDR_W  display fetch address.
REQ-008 disp_gnt  out  1  display request accepted this cycle.
REQ-009 disp_valid  out  1  disp_data valid.
REQ-010 disp_data  out  DATA_W  display read data.
REQ-011 cpu_req  in  1  game-logic (collision) request.
REQ-012 cpu_addr  in  ADDR_W  game-logic fetch address.
REQ-013 cpu_gnt  out  1  game-logic request accepted this cycle.
REQ-014 cpu_valid  out  1  cpu_data valid.
REQ-015 cpu_data  out  DATA_W  game-logic read data.
REQ-016 rom_addr  out  ADDR_W  address to the shared synchronous ROM (1-cycle read latency).
REQ-017 rom_q  in  DATA_W  ROM read data.
REQ-018 disp_miss  out  1  one-cycle pulse: display request denied.
REQ-019 miss_count  out  16  saturating count of disp_miss pulses.

Function
REQ-020 Arbitration SHALL be combinational each cycle; at most one of disp_gnt, cpu_gnt high.
REQ-021 Default priority: disp_req wins; cpu_gnt only when disp_req low or force condition holds.
REQ-022 starve_cnt (4 bits) SHALL increment each cycle cpu_req high and cpu_gnt low; clear on cpu_gnt or cpu_req low.
REQ-023 Force condition: starve_cnt == STARVE_MAX and cpu_req high -> cpu_gnt=1, disp_gnt=0 regardless of disp_req.
REQ-024 disp_miss SHALL be high combinationally in any cycle disp_req=1 and disp_gnt=0.
REQ-025 miss_count SHALL increment on each clock edge where disp_miss=1, saturating at 16'hFFFF.
REQ-026 rom_addr = disp_addr when disp_gnt, cpu_addr when cpu_gnt, else 0.
REQ-027 Owner register SHALL take NONE/DISP/CPU from the grant of the current cycle.
REQ-028 One cycle after a grant: owner DISP -> disp_valid=1, disp_data=rom_q; owner CPU -> cpu_valid=1, cpu_data=rom_q; valid outputs combinational from owner register.
REQ-029 Non-owning data output SHALL be 0; valid high exactly one cycle per grant.
REQ-030 Requesters SHALL hold req and addr until gnt; back-to-back grants every cycle supported (throughput 1/cycle).
REQ-031 Request dropped before grant SHALL not produce grant, valid, or counter change beyond REQ-022 clearing.

Reset
REQ-032 reset_n low SHALL immediately clear owner to NONE, starve_cnt to 0, miss_count to 0; all grant/valid/data/rom_addr/disp_miss outputs 0 while reset_n low.
REQ-033 Reset asserted with a read in flight SHALL discard it: no valid pulse after release.
REQ-034 First grant possible in the first cycle after reset_n deasserts.

Verification
REQ-035 Display only: disp_req=1, addr 0..4 one per cycle -> disp_gnt each cycle, disp_valid next cycle with matching ROM contents, disp_miss=0.
REQ-036 CPU alone in blanking: cpu_req=1 addr 13'h0100, disp_req=0 -> cpu_gnt same cycle, rom_addr=13'h0100, cpu_valid next cycle, disp_valid=0.
REQ-037 Starvation: disp_req and cpu_req held high, STARVE_MAX=8 -> cpu_gnt on 9th cycle, disp_miss pulse that cycle, miss_count=1, starve_cnt back to 0.
REQ-038 Saturation: force 70000 misses -> miss_count stays 16'hFFFF.
REQ-039 Reset mid-flight: grant CPU, assert reset_n low before next edge, release -> cpu_valid never asserts, all counters 0.
REQ-040 Interleave: alternating disp/cpu requests every cycle -> each valid routed to correct port, data never crossed.
